commit_trace_tx: RTL and testbench

Retirement-trace transmitter for the single-cycle MIPS core. Each cycle it captures the commit record of the retiring instruction: PC, instruction word, instruction class, register indices and register values. It buffers records in a small FIFO and serialises each one as a 6-word packet on a 32-bit valid/ready stream. The stream feeds an off-core checker or trace sink, and the block back-pressures the core with a stall when its buffer fills.

---
 rtl/commit_trace_tx.sv | 184 ++++++++++++++++++
 tb/tb_commit_trace_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_tx.sv
// Retirement-trace transmitter: buffers per-cycle commit records in a small FIFO
// and serialises each record as a 6-word packet on a 32-bit valid/ready stream.
module commit_trace_tx #(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_en,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_instr,
    input  logic [1:0]  commit_type,
    input  logic        commit_wr,
    input  logic [4:0]  commit_dst,
    input  logic [4:0]  commit_rs,
    input  logic [4:0]  commit_rt,
    input  logic [31:0] commit_rs_val,
    input  logic [31:0] commit_rt_val,
    input  logic [31:0] commit_dst_val,
    output logic        stall_o,
    output logic        tvalid,
    input  logic        tready,
    output logic [31:0] tdata,
    output logic        tlast,
    output logic        overflow,
    output logic [2:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [11:0] seq;
        logic [1:0]  typ;
        logic        wr;
        logic [4:0]  dst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] dst_val;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_W0   = 3'd1,
        S_W1   = 3'd2,
        S_W2   = 3'd3,
        S_W3   = 3'd4,
        S_W4   = 3'd5,
        S_W5   = 3'd6
    } state_t;

    // Stream handshake: a word transfers on any rising edge where tvalid && tready;
    // while tvalid && !tready, tdata and tlast hold their value.

    rec_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [SEQ_W-1:0] seq_q;
    logic            overflow_q;
    state_t          state_q;
    state_t          state_d;
    logic [31:0]     tdata_q;
    logic            tlast_q;

    logic            full;
    logic            push;
    logic            drop;
    logic            pop;
    rec_t            push_rec;
    rec_t            next_rec;
    logic [AW-1:0]   head_idx;
    logic [AW:0]     remaining;
    logic [31:0]     tdata_d;
    logic            tlast_d;

    assign full = (count == (AW+1)'(DEPTH));
    assign push = trace_en && commit_valid && !full;
    assign drop = trace_en && commit_valid && full;

    always_comb begin
        push_rec         = '0;
        push_rec.seq     = 12'(seq_q);
        push_rec.typ     = commit_type;
        push_rec.wr      = commit_wr;
        push_rec.dst     = commit_dst;
        push_rec.rs      = commit_rs;
        push_rec.rt      = commit_rt;
        push_rec.pc      = commit_pc;
        push_rec.instr   = commit_instr;
        push_rec.rs_val  = commit_rs_val;
        push_rec.rt_val  = commit_rt_val;
        push_rec.dst_val = commit_wr ? commit_dst_val : 32'h0;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (count != '0 || push) state_d = S_W0;
            S_W0:   if (tready) state_d = S_W1;
            S_W1:   if (tready) state_d = S_W2;
            S_W2:   if (tready) state_d = S_W3;
            S_W3:   if (tready) state_d = S_W4;
            S_W4:   if (tready) state_d = S_W5;
            S_W5: begin
                if (tready) begin
                    pop     = 1'b1;
                    state_d = (count > (AW+1)'(1) || push) ? S_W0 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The record feeding the next registered word; a push landing in an
    // otherwise-empty FIFO is forwarded directly so no idle cycle is inserted.
    always_comb begin
        head_idx  = rd_ptr + AW'(pop);
        remaining = pop ? (count - (AW+1)'(1)) : count;
        next_rec  = (remaining == '0) ? push_rec : mem[head_idx];
    end

    function automatic logic [31:0] word_of(input state_t s, input rec_t r);
        logic [31:0] w;
        case (s)
            S_W0:    w = {r.seq, r.typ, r.wr, r.dst, r.rs, r.rt, 2'b00};
            S_W1:    w = r.pc;
            S_W2:    w = r.instr;
            S_W3:    w = r.rs_val;
            S_W4:    w = r.rt_val;
            S_W5:    w = r.dst_val;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    assign tdata_d = word_of(state_d, next_rec);
    assign tlast_d = (state_d == S_W5);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tdata_q    <= 32'h0;
            tlast_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                seq_q  <= seq_q + SEQ_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign tvalid    = (state_q != S_IDLE);
    assign tdata     = tdata_q;
    assign tlast     = tlast_q;
    assign stall_o   = trace_en && full;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: packet format, back-pressure, FIFO full,
// sequence wrap, no-write records and reset in the middle of a packet.
module tb_commit_trace_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic [1:0]  commit_type;
    logic        commit_wr;
    logic [4:0]  commit_dst;
    logic [4:0]  commit_rs;
    logic [4:0]  commit_rt;
    logic [31:0] commit_rs_val;
    logic [31:0] commit_rt_val;
    logic [31:0] commit_dst_val;
    logic        stall_o;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic        overflow;
    logic [2:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    int n_hs    = 0;

    commit_trace_tx #(.DEPTH(4), .SEQ_W(12)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_type(commit_type),
        .commit_wr(commit_wr), .commit_dst(commit_dst), .commit_rs(commit_rs),
        .commit_rt(commit_rt), .commit_rs_val(commit_rs_val), .commit_rt_val(commit_rt_val),
        .commit_dst_val(commit_dst_val), .stall_o(stall_o), .tvalid(tvalid), .tready(tready),
        .tdata(tdata), .tlast(tlast), .overflow(overflow), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        if (tvalid === 1'b1 && tready === 1'b1) n_hs++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [1:0] typ, input logic wr, input logic [4:0] dst,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [31:0] rsv, input logic [31:0] rtv,
                              input logic [31:0] dv);
        commit_valid   = 1'b1;
        commit_pc      = pc;
        commit_instr   = instr;
        commit_type    = typ;
        commit_wr      = wr;
        commit_dst     = dst;
        commit_rs      = rs;
        commit_rt      = rt;
        commit_rs_val  = rsv;
        commit_rt_val  = rtv;
        commit_dst_val = dv;
    endtask

    task automatic do_reset();
        commit_valid = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_w [6];
        int pushes, packets, word, bad, wrap_seen;
        logic [11:0] exp_seq, last_seq, seq;

        reset = 1'b0; trace_en = 1'b1; tready = 1'b1;
        set_commit(32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        commit_valid = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_tvalid", 32'(tvalid), 32'h0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_tlast", 32'(tlast), 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);

        // Single R-type commit: add $8,$9,$10
        set_commit(32'h0040_0000, 32'h012A_4020, 2'b01, 1'b1, 5'd8, 5'd9, 5'd10,
                   32'h5, 32'h7, 32'hC);
        step();
        commit_valid = 1'b0;
        exp_w[0] = 32'h0006_84A8; exp_w[1] = 32'h0040_0000; exp_w[2] = 32'h012A_4020;
        exp_w[3] = 32'h5;         exp_w[4] = 32'h7;         exp_w[5] = 32'hC;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("r_word%0d", k), tdata, exp_w[k]);
            check($sformatf("r_tlast%0d", k), 32'(tlast), (k == 5) ? 32'h1 : 32'h0);
            step();
        end
        check("r_idle_after", 32'(tvalid), 32'h0);

        // Back-pressure during W2 (seq 1, I-type lw)
        n_hs = 0;
        set_commit(32'h0040_0004, 32'h8C83_0000, 2'b10, 1'b1, 5'd3, 5'd4, 5'd0,
                   32'h100, 32'h0, 32'h1234);
        step();
        commit_valid = 1'b0;
        check("bp_header", tdata, 32'h001A_3200);
        step();
        step();
        check("bp_w2_c0", tdata, 32'h8C83_0000);
        tready = 1'b0;
        step();
        check("bp_w2_c1", tdata, 32'h8C83_0000);
        step();
        check("bp_w2_c2", tdata, 32'h8C83_0000);
        check("bp_w2_valid", 32'(tvalid), 32'h1);
        tready = 1'b1;
        step();
        check("bp_w3", tdata, 32'h100);
        step();
        step();
        check("bp_w5", tdata, 32'h1234);
        check("bp_w5_tlast", 32'(tlast), 32'h1);
        step();
        check("bp_handshakes", 32'(n_hs), 32'd6);

        // Full FIFO: 5 commits with sink stalled
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) check("full_stall_before4", 32'(stall_o), 32'h0);
            set_commit(32'h1000 + 32'(4 * i), 32'h0, 2'b10, 1'b0, 5'd0, 5'd0, 5'd0,
                       32'h0, 32'h0, 32'h0);
            step();
            if (i == 3) check("full_stall_after4", 32'(stall_o), 32'h1);
        end
        commit_valid = 1'b0;
        check("full_overflow", 32'(overflow), 32'h1);
        check("full_w0_held", tdata, 32'h0008_0000);
        trace_en = 1'b0;
        #1;
        check("full_stall_trace_off", 32'(stall_o), 32'h0);
        trace_en = 1'b1;
        #1;
        tready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 6; k++) begin
                if (k == 0) check($sformatf("drain_hdr%0d", p), tdata, (32'(p) << 20) | 32'h0008_0000);
                if (k == 1) check($sformatf("drain_pc%0d", p), tdata, 32'h1000 + 32'(4 * p));
                if (p == 0 && k == 5) check("drain_stall_pre_pop", 32'(stall_o), 32'h1);
                step();
                if (p == 0 && k == 5) check("drain_stall_post_pop", 32'(stall_o), 32'h0);
            end
        end
        check("drain_idle", 32'(tvalid), 32'h0);

        // J-type, no register write; seq continues at 4 since the drop did not advance it
        set_commit(32'h0040_0100, 32'h0C10_0000, 2'b11, 1'b0, 5'd31, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'hDEAD);
        step();
        commit_valid = 1'b0;
        check("j_header", tdata, 32'h004D_F000);
        for (int k = 0; k < 5; k++) step();
        check("j_w5_zero", tdata, 32'h0);
        check("j_tlast", 32'(tlast), 32'h1);
        check("j_overflow_sticky", 32'(overflow), 32'h1);
        step();

        // Reset while the packet is in W3, with the FIFO full behind it
        set_commit(32'h0040_0200, 32'h012A_4020, 2'b01, 1'b1, 5'd8, 5'd9, 5'd10,
                   32'h5, 32'h7, 32'hC);
        step();
        commit_valid = 1'b0;
        step();
        step();
        step();
        check("mid_state_w3", 32'(dbg_state), 32'd4);
        check("mid_w3_data", tdata, 32'h5);
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_commit(32'h2000, 32'h0, 2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
            step();
        end
        commit_valid = 1'b0;
        check("mid_stall_full", 32'(stall_o), 32'h1);
        reset = 1'b0;
        step();
        check("mid_rst_tvalid", 32'(tvalid), 32'h0);
        check("mid_rst_stall", 32'(stall_o), 32'h0);
        check("mid_rst_tdata", tdata, 32'h0);
        check("mid_rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b1;
        tready = 1'b1;
        set_commit(32'h0040_0000, 32'h012A_4020, 2'b01, 1'b1, 5'd8, 5'd9, 5'd10,
                   32'h5, 32'h7, 32'hC);
        step();
        commit_valid = 1'b0;
        check("mid_post_hdr_seq0", tdata, 32'h0006_84A8);
        for (int k = 0; k < 6; k++) step();
        check("mid_post_idle", 32'(tvalid), 32'h0);

        // Sequence wrap: 4097 commits, stall honoured
        do_reset();
        tready = 1'b1;
        pushes = 0; packets = 0; word = 0; bad = 0; wrap_seen = 0;
        exp_seq = 12'h0; last_seq = 12'h0;
        set_commit(32'h0040_0000, 32'h012A_4020, 2'b01, 1'b1, 5'd8, 5'd9, 5'd10,
                   32'h5, 32'h7, 32'hC);
        for (int cyc = 0; cyc < 40000 && packets < 4097; cyc++) begin
            commit_valid = (pushes < 4097) && !stall_o;
            commit_pc = 32'(pushes);
            if (commit_valid) pushes++;
            if (tvalid && tready) begin
                if (word == 0) begin
                    seq = tdata[31:20];
                    if (seq != exp_seq) bad++;
                    if (packets > 0 && last_seq == 12'hFFF && seq == 12'h000) wrap_seen = 1;
                    last_seq = seq;
                    exp_seq = exp_seq + 12'h1;
                end
                if ((word == 5) != tlast) bad++;
                if (word == 5) packets++;
                word = (word == 5) ? 0 : word + 1;
            end
            step();
        end
        commit_valid = 1'b0;
        check("wrap_pushes", 32'(pushes), 32'd4097);
        check("wrap_packets", 32'(packets), 32'd4097);
        check("wrap_seq_errors", 32'(bad), 32'd0);
        check("wrap_seen_fff_to_000", 32'(wrap_seen), 32'd1);
        check("wrap_overflow", 32'(overflow), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
